// File: rtl/mcb_port_arbiter.sv
// Purpose : shares one MCB user port between a write requester (A) and a read requester (B).
// Latency : an eligible request seen in IDLE drives cmd_en and its done pulse on the next edge.
// Backpressure: no grant while cmd_full is high; writes wait for data in the write FIFO, reads wait for read FIFO space.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   mem_calib_done      - MCB calibration complete; low forces the FSM back to INIT
//   a_* / b_*           - write / read requester: level req, byte address, burst length-1,
//                         one-cycle done (command issued) and err (misaligned) pulses
//   cmd_*               - MCB command interface (cmd_full is the command FIFO full flag)
//   wr_count, rd_count  - word occupancy of the port write / read FIFOs
//   busy                - high while a command is issuing or the post-issue hold runs
module mcb_port_arbiter #(
    parameter int STARVE_LIMIT  = 8,
    parameter int HOLD_CYCLES   = 2,
    parameter int RD_FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        a_req,
    input  logic [29:0] a_byte_addr,
    input  logic [5:0]  a_bl,
    output logic        a_done,
    output logic        a_err,
    input  logic        b_req,
    input  logic [29:0] b_byte_addr,
    input  logic [5:0]  b_bl,
    output logic        b_done,
    output logic        b_err,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    input  logic [6:0]  wr_count,
    input  logic [6:0]  rd_count,
    output logic        busy
);

    localparam logic [3:0] LP_STARVE    = 4'(STARVE_LIMIT);
    localparam logic [2:0] LP_HOLD_LAST = 3'(HOLD_CYCLES - 1);
    localparam logic [6:0] LP_DEPTH     = 7'(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic [2:0] r_hold_cnt;

    logic [6:0] w_a_need;
    logic [6:0] w_b_need;
    logic [6:0] w_rd_free;
    logic       w_a_misal;
    logic       w_b_misal;
    logic       w_a_elig;
    logic       w_b_elig;
    logic       w_starved;
    logic       w_grant_a;
    logic       w_grant_b;

    assign w_a_need  = {1'b0, a_bl} + 7'd1;
    assign w_b_need  = {1'b0, b_bl} + 7'd1;
    // An over-reported read count must not wrap into a large free-space value.
    assign w_rd_free = (rd_count > LP_DEPTH) ? 7'd0 : (LP_DEPTH - rd_count);

    assign w_a_misal = a_req && (a_byte_addr[1:0] != 2'b00);
    assign w_b_misal = b_req && (b_byte_addr[1:0] != 2'b00);
    assign w_a_elig  = a_req && (a_byte_addr[1:0] == 2'b00) && (wr_count >= w_a_need);
    assign w_b_elig  = b_req && (b_byte_addr[1:0] == 2'b00) && (w_rd_free >= w_b_need);
    assign w_starved = (r_starve_cnt == LP_STARVE);

    // Reads win ties unless the writer has been passed over STARVE_LIMIT times.
    assign w_grant_a = !cmd_full && w_a_elig && (!w_b_elig || w_starved);
    assign w_grant_b = !cmd_full && w_b_elig && !w_grant_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_starve_cnt  <= 4'd0;
            r_hold_cnt    <= 3'd0;
            a_done        <= 1'b0;
            a_err         <= 1'b0;
            b_done        <= 1'b0;
            b_err         <= 1'b0;
            cmd_en        <= 1'b0;
            cmd_instr     <= 3'b000;
            cmd_bl        <= 6'd0;
            cmd_byte_addr <= 30'd0;
            busy          <= 1'b0;
        end else begin
            cmd_en <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            a_err  <= 1'b0;
            b_err  <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    if (mem_calib_done) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (!mem_calib_done) begin
                        r_state <= ST_INIT;
                    end else begin
                        if (!a_req) begin
                            r_starve_cnt <= 4'd0;
                        end
                        // The requester only drops req after seeing err, so a
                        // pulse already high suppresses a repeat on that cycle.
                        a_err <= w_a_misal && !a_err;
                        b_err <= w_b_misal && !b_err;

                        if (w_grant_a) begin
                            cmd_instr     <= 3'b000;
                            cmd_bl        <= a_bl;
                            cmd_byte_addr <= a_byte_addr;
                            cmd_en        <= 1'b1;
                            a_done        <= 1'b1;
                            busy          <= 1'b1;
                            r_starve_cnt  <= 4'd0;
                            r_state       <= ST_ISSUE;
                        end else if (w_grant_b) begin
                            cmd_instr     <= 3'b001;
                            cmd_bl        <= b_bl;
                            cmd_byte_addr <= b_byte_addr;
                            cmd_en        <= 1'b1;
                            b_done        <= 1'b1;
                            busy          <= 1'b1;
                            if (a_req && !w_starved) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                            r_state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_hold_cnt <= 3'd0;
                    if (!mem_calib_done) begin
                        busy    <= 1'b0;
                        r_state <= ST_INIT;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (!mem_calib_done) begin
                        busy    <= 1'b0;
                        r_state <= ST_INIT;
                    end else if (r_hold_cnt == LP_HOLD_LAST) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 3'd1;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Purpose : directed, table-driven check of mcb_port_arbiter plus multi-cycle sequences.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: cmd_full and FIFO counts are driven directly by the bench.
module tb_mcb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_calib_done;
    logic        a_req;
    logic [29:0] a_byte_addr;
    logic [5:0]  a_bl;
    logic        a_done;
    logic        a_err;
    logic        b_req;
    logic [29:0] b_byte_addr;
    logic [5:0]  b_bl;
    logic        b_done;
    logic        b_err;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic [6:0]  wr_count;
    logic [6:0]  rd_count;
    logic        busy;

    always #5 clk = ~clk;

    mcb_port_arbiter #(
        .STARVE_LIMIT (8),
        .HOLD_CYCLES  (2),
        .RD_FIFO_DEPTH(64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_calib_done(mem_calib_done),
        .a_req         (a_req),
        .a_byte_addr   (a_byte_addr),
        .a_bl          (a_bl),
        .a_done        (a_done),
        .a_err         (a_err),
        .b_req         (b_req),
        .b_byte_addr   (b_byte_addr),
        .b_bl          (b_bl),
        .b_done        (b_done),
        .b_err         (b_err),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_full      (cmd_full),
        .wr_count      (wr_count),
        .rd_count      (rd_count),
        .busy          (busy)
    );

    typedef struct {
        string       name;
        logic        calib;
        logic        a_req;
        logic [29:0] a_addr;
        logic [5:0]  a_bl;
        logic        b_req;
        logic [29:0] b_addr;
        logic [5:0]  b_bl;
        logic        full;
        logic [6:0]  wr;
        logic [6:0]  rd;
        logic [44:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {cmd_en, a_done, b_done, a_err, b_err, busy, cmd_instr, cmd_bl, cmd_byte_addr}
    function automatic logic [44:0] outs();
        return {cmd_en, a_done, b_done, a_err, b_err, busy, cmd_instr, cmd_bl, cmd_byte_addr};
    endfunction

    function automatic logic [44:0] mk(input logic en, input logic ad, input logic bd,
                                       input logic ae, input logic be, input logic bs,
                                       input logic [2:0] ins, input logic [5:0] bl,
                                       input logic [29:0] addr);
        return {en, ad, bd, ae, be, bs, ins, bl, addr};
    endfunction

    task automatic add(input string nm, input logic calib,
                       input logic ar, input logic [29:0] aa, input logic [5:0] ab,
                       input logic br, input logic [29:0] ba, input logic [5:0] bb,
                       input logic full, input logic [6:0] wr, input logic [6:0] rd,
                       input logic [44:0] exp);
        vec_t v;
        v.name = nm;   v.calib = calib;
        v.a_req = ar;  v.a_addr = aa; v.a_bl = ab;
        v.b_req = br;  v.b_addr = ba; v.b_bl = bb;
        v.full = full; v.wr = wr;     v.rd = rd;
        v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        mem_calib_done = 1'b0;
        a_req = 1'b0; a_byte_addr = 30'd0; a_bl = 6'd0;
        b_req = 1'b0; b_byte_addr = 30'd0; b_bl = 6'd0;
        cmd_full = 1'b0; wr_count = 7'd0; rd_count = 7'd0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int          cnt;
    int          ng;
    int          c_first;
    int          gap;
    logic [17:0] pattern;
    logic [3:0]  busy_seq;

    initial begin
        reset = 1'b1;
        idle_inputs();

        // name, calib, a_req,a_addr,a_bl, b_req,b_addr,b_bl, full, wr, rd, expected outputs
        add("a_issue",        1, 1, 30'h100, 6'd15, 0, 30'h0,   6'd0,  0, 7'd16, 7'd0,   mk(1,1,0,0,0,1,3'b000,6'd15,30'h100));
        add("a_wr_short",     1, 1, 30'h100, 6'd15, 0, 30'h0,   6'd0,  0, 7'd15, 7'd0,   mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("a_bl63_ok",      1, 1, 30'h004, 6'd63, 0, 30'h0,   6'd0,  0, 7'd64, 7'd0,   mk(1,1,0,0,0,1,3'b000,6'd63,30'h004));
        add("a_bl63_short",   1, 1, 30'h004, 6'd63, 0, 30'h0,   6'd0,  0, 7'd63, 7'd0,   mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("b_issue",        1, 0, 30'h0,   6'd0,  1, 30'h40,  6'd31, 0, 7'd0,  7'd32,  mk(1,0,1,0,0,1,3'b001,6'd31,30'h40));
        add("b_space_short",  1, 0, 30'h0,   6'd0,  1, 30'h40,  6'd31, 0, 7'd0,  7'd40,  mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("b_bl63_empty",   1, 0, 30'h0,   6'd0,  1, 30'h80,  6'd63, 0, 7'd0,  7'd0,   mk(1,0,1,0,0,1,3'b001,6'd63,30'h80));
        add("b_rd_overfull",  1, 0, 30'h0,   6'd0,  1, 30'h80,  6'd0,  0, 7'd0,  7'd100, mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("b_rd_full",      1, 0, 30'h0,   6'd0,  1, 30'h80,  6'd0,  0, 7'd0,  7'd64,  mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("both_b_wins",    1, 1, 30'h200, 6'd3,  1, 30'h300, 6'd7,  0, 7'd4,  7'd0,   mk(1,0,1,0,0,1,3'b001,6'd7,30'h300));
        add("both_cmd_full",  1, 1, 30'h200, 6'd3,  1, 30'h300, 6'd7,  1, 7'd4,  7'd0,   mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("a_wins_b_space", 1, 1, 30'h200, 6'd3,  1, 30'h300, 6'd7,  0, 7'd4,  7'd60,  mk(1,1,0,0,0,1,3'b000,6'd3,30'h200));
        add("a_misal",        1, 1, 30'h102, 6'd0,  0, 30'h0,   6'd0,  0, 7'd64, 7'd0,   mk(0,0,0,1,0,0,3'b000,6'd0,30'h0));
        add("a_misal_b_ok",   1, 1, 30'h102, 6'd0,  1, 30'h300, 6'd7,  0, 7'd64, 7'd0,   mk(1,0,1,1,0,1,3'b001,6'd7,30'h300));
        add("both_misal",     1, 1, 30'h102, 6'd0,  1, 30'h301, 6'd7,  0, 7'd64, 7'd0,   mk(0,0,0,1,1,0,3'b000,6'd0,30'h0));
        add("b_misal_nospc",  1, 0, 30'h0,   6'd0,  1, 30'h303, 6'd7,  0, 7'd0,  7'd64,  mk(0,0,0,0,1,0,3'b000,6'd0,30'h0));
        add("a_noreq_misal",  1, 0, 30'h102, 6'd0,  0, 30'h0,   6'd0,  0, 7'd64, 7'd0,   mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));
        add("no_calib",       0, 1, 30'h100, 6'd15, 0, 30'h0,   6'd0,  0, 7'd16, 7'd0,   mk(0,0,0,0,0,0,3'b000,6'd0,30'h0));

        // ---------------- table-driven single decisions from IDLE ----------------
        for (int i = 0; i < vq.size(); i++) begin
            reset_dut();
            mem_calib_done = 1'b1;
            tick();                      // INIT -> IDLE
            mem_calib_done = vq[i].calib;
            a_req = vq[i].a_req; a_byte_addr = vq[i].a_addr; a_bl = vq[i].a_bl;
            b_req = vq[i].b_req; b_byte_addr = vq[i].b_addr; b_bl = vq[i].b_bl;
            cmd_full = vq[i].full; wr_count = vq[i].wr; rd_count = vq[i].rd;
            tick();
            check(vq[i].name, 64'(outs()), 64'(vq[i].exp));
        end

        // ---------------- calibration gating ----------------
        reset_dut();
        check("reset_outputs", 64'(outs()), 64'd0);
        a_req = 1'b1; a_byte_addr = 30'h100; a_bl = 6'd15; wr_count = 7'd16;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            cnt += int'(cmd_en);
        end
        check("calib_low_no_cmd", 64'(cnt), 64'd0);
        mem_calib_done = 1'b1;
        tick();
        check("calib_plus1_no_cmd", 64'(cmd_en), 64'd0);
        tick();
        check("calib_plus2_issue", 64'(outs()), 64'(mk(1,1,0,0,0,1,3'b000,6'd15,30'h100)));
        a_req = 1'b0;
        tick();
        check("cmd_en_one_cycle", 64'({cmd_en, a_done}), 64'd0);

        // ---------------- read space gating and busy window ----------------
        reset_dut();
        mem_calib_done = 1'b1;
        tick();
        b_req = 1'b1; b_byte_addr = 30'h40; b_bl = 6'd31; rd_count = 7'd40;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            cnt += int'(cmd_en);
        end
        check("rd_space_blocked", 64'(cnt), 64'd0);
        rd_count = 7'd32;
        tick();
        check("rd_issue", 64'({cmd_en, b_done, cmd_instr}), 64'({1'b1, 1'b1, 3'b001}));
        b_req = 1'b0;
        busy_seq[3] = busy;
        for (int k = 2; k >= 0; k--) begin
            tick();
            busy_seq[k] = busy;
        end
        check("busy_window", 64'(busy_seq), 64'(4'b1110));

        // ---------------- priority and starvation ----------------
        reset_dut();
        mem_calib_done = 1'b1;
        tick();
        a_req = 1'b1; a_byte_addr = 30'h200; a_bl = 6'd3; wr_count = 7'd4;
        b_req = 1'b1; b_byte_addr = 30'h300; b_bl = 6'd7; rd_count = 7'd0;
        pattern = '0; ng = 0; c_first = 0; gap = 0;
        for (int c = 0; c < 300 && ng < 18; c++) begin
            tick();
            if (cmd_en) begin
                pattern[ng] = a_done;
                if (ng == 0) c_first = c;
                if (ng == 1) gap = c - c_first;
                if (ng == 7) check("starve_at_limit", 64'(dut.r_starve_cnt), 64'd8);
                if (ng == 8) check("starve_cleared", 64'(dut.r_starve_cnt), 64'd0);
                ng++;
            end
        end
        check("grant_count", 64'(ng), 64'd18);
        check("grant_pattern", 64'(pattern), 64'(18'h20100));
        check("cmd_spacing", 64'(gap), 64'd4);
        a_req = 1'b0; b_req = 1'b0;

        // ---------------- misaligned err is a single pulse ----------------
        reset_dut();
        mem_calib_done = 1'b1;
        tick();
        a_req = 1'b1; a_byte_addr = 30'h102; a_bl = 6'd0; wr_count = 7'd64;
        tick();
        check("misal_err_pulse", 64'({a_err, cmd_en}), 64'({1'b1, 1'b0}));
        tick();
        check("misal_err_one_cycle", 64'(a_err), 64'd0);
        a_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            cnt += int'(a_err) + int'(cmd_en);
        end
        check("misal_no_issue", 64'(cnt), 64'd0);

        // ---------------- back-pressure then reset in HOLD ----------------
        reset_dut();
        mem_calib_done = 1'b1;
        tick();
        a_req = 1'b1; a_byte_addr = 30'h100; a_bl = 6'd15; wr_count = 7'd16;
        cmd_full = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            cnt += int'(cmd_en);
        end
        check("cmd_full_blocks", 64'(cnt), 64'd0);
        cmd_full = 1'b0;
        tick();
        check("cmd_full_release", 64'({cmd_en, a_done}), 64'({1'b1, 1'b1}));
        a_req = 1'b0;
        tick();
        check("in_hold_busy", 64'({busy, cmd_en}), 64'({1'b1, 1'b0}));
        reset = 1'b1;
        tick();
        check("reset_in_hold", 64'(outs()), 64'd0);
        reset = 1'b0;
        mem_calib_done = 1'b0;
        a_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            cnt += int'(cmd_en);
        end
        check("post_reset_init", 64'(cnt), 64'd0);
        mem_calib_done = 1'b1;
        tick();
        check("reinit_plus1", 64'(cmd_en), 64'd0);
        tick();
        check("reinit_plus2", 64'({cmd_en, a_done}), 64'({1'b1, 1'b1}));
        a_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcb_port_arbiter.md
# mcb_port_arbiter

Shares a single MCB user port between two requesters: the render-side write requester (A) and the display-side read requester (B). It sequences one command at a time onto the port and gates each grant on the port's FIFO occupancy, so a write only issues when its burst data is already queued and a read only issues when the read FIFO has room for the returned burst. Read priority protects the real-time display path. A bounded starvation counter guarantees forward progress for rendering.

## Interface
Parameters:
- STARVE_LIMIT, 8: maximum consecutive B grants while A is pending before A is forced; range 1–15.
- HOLD_CYCLES, 2: idle cycles after each issued command, allowing MCB FIFO counts to settle; range 1–7.
- RD_FIFO_DEPTH, 64: read FIFO depth in 32-bit words.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- mem_calib_done  in  1  MCB calibration complete.
- a_req  in  1  write request; level, held until a_done or a_err.
- a_byte_addr  in  30  write byte address.
- a_bl  in  6  write burst length minus 1.
- a_done  out  1  one-cycle pulse: A command issued.
- a_err  out  1  one-cycle pulse: A rejected for misalignment.
- b_req, b_byte_addr, b_bl, b_done, b_err: same as the A ports, for reads.
- cmd_en  out  1  MCB command strobe.
- cmd_instr  out  3  3'b000 write, 3'b001 read.
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  30  command address.
- cmd_full  in  1  MCB command FIFO full.
- wr_count  in  7  words in the port write FIFO.
- rd_count  in  7  words in the port read FIFO.
- busy  out  1  high in ISSUE or HOLD.

## Operation
- **States:** INIT, IDLE, ISSUE, HOLD.
- **INIT:** stays in INIT until mem_calib_done=1, then moves to IDLE. If mem_calib_done drops in any state, the FSM returns to INIT after completing the current ISSUE cycle.
- **A eligible** when all of the following hold:
  - a_req=1
  - a_byte_addr[1:0]=0
  - wr_count ≥ a_bl+1
- **B eligible** when all of the following hold:
  - b_req=1
  - b_byte_addr[1:0]=0
  - RD_FIFO_DEPTH − rd_count ≥ b_bl+1
- **Misalignment:** a request with addr[1:0]≠0 gets its err pulse in IDLE, in place of a grant, and never issues. The requester must deassert req after the err pulse.
- **IDLE decision:** taken only when cmd_full=0.
  - If both A and B are eligible, B wins unless starve_cnt = STARVE_LIMIT, in which case A wins.
  - Otherwise the single eligible requester wins.
  - If neither is eligible, stay in IDLE.
- **Latching:** the winner's instruction, burst length and address are registered, and the FSM moves to ISSUE.
- **ISSUE:** lasts exactly one cycle.
  - cmd_en=1 with the registered fields.
  - The winner's done pulse is asserted in the same cycle.
  - Then move to HOLD.
- **HOLD:** lasts HOLD_CYCLES cycles, then returns to IDLE. Requests are ignored during HOLD.
- **starve_cnt (4-bit):**
  - Increments on each B issue while a_req=1 and A was not eligible or lost arbitration.
  - Clears on any A issue, or when a_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- **Counts:** wr_count and rd_count are compared using 7-bit unsigned arithmetic, with a_bl+1 and b_bl+1 zero-extended to 7 bits. rd_count > RD_FIFO_DEPTH is treated as zero free space.
- **Simultaneous misalignment:** if both requests are misaligned in the same IDLE cycle, both err pulses fire that cycle.

## Timing
- **Reset values:** all outputs are 0, the state is INIT and starve_cnt=0. Reset during ISSUE or HOLD aborts immediately. Reset has no effect on the MCB, and a command already strobed is not recalled.
- **Latency:** from an eligible request sampled in IDLE, cmd_en and done assert on the next edge (1-cycle latency).
- **Back-to-back commands:** minimum spacing between two cmd_en pulses is 1 + HOLD_CYCLES + 1 cycles (4 cycles with defaults).
- **cmd_en / done width:** never high for more than one cycle; never high outside ISSUE.
- **Requester hold rule:** requesters hold addr and bl stable from req rise until done/err. A may drop req only after done or err; dropping earlier is illegal and is not checked.
- **cmd_full:** if cmd_full rises in the same cycle as the IDLE decision, no transition occurs and the decision is retried the next cycle.

## Test plan
- **Calibration gating:** mem_calib_done=0 for 100 cycles with a_req=1, addr=0x100, bl=15, wr_count=16 → no cmd_en. Raise mem_calib_done → cmd_en with cmd_instr=000, cmd_bl=15, cmd_byte_addr=0x100 exactly 2 cycles later; a_done in the same cycle as cmd_en.
- **Read space gating:** b_req=1, bl=31, rd_count=40 → no issue (24 words free). Drop rd_count to 32 → issue read (cmd_instr=001), then busy for 3 cycles.
- **Priority and starvation:** both requesters eligible continuously → B issues 8 times, A issues 9th, then B resumes; starve_cnt returns to 0 after the A issue.
- **Misalignment:** a_byte_addr=0x102 → one-cycle a_err, no cmd_en. Misaligned A together with valid B in the same cycle → a_err and the B issue both occur.
- **Back-pressure and reset:** cmd_full=1 with eligible A → no cmd_en; releasing cmd_full → issue next cycle. Assert reset while in HOLD → all outputs 0 next edge; after reset the FSM re-enters INIT.
